sensor_poll_scheduler: RTL
==========================

# sensor_poll_scheduler

Parametrised multi-channel I2C sensor poller. Sits between the system and a single `i2c_controller` master. It reads NUM_CH sensor slaves round-robin at a fixed poll period and caches the latest byte per channel. Each reading is checked against per-channel limits, and cached values are exposed through an indexed read port, so software never waits on the bus.

## Interface
Parameters:
- NUM_CH, 2, number of sensor channels (1..16)
- ADDR_LIST, {7'h2B, 7'h2A}, packed 7-bit slave addresses; channel i = ADDR_LIST[7*i +: 7]
- LO_LIMIT, {8'd40, 8'd0}, packed per-channel lower limit; channel i = LO_LIMIT[8*i +: 8]
- HI_LIMIT, {8'd100, 8'd40}, packed per-channel upper limit, same packing
- POLL_PERIOD, 1000, idle cycles between end of one round and start of the next (>=1)
- TIMEOUT, 4096, max cycles per transaction before the channel is flagged failed (>=4)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- run  in  1  level; 1 = polling enabled
- poll_now  in  1  pulse; start a round immediately if waiting
- rd_ch  in  4  channel index for cache read
- rd_data  out  8  cached reading of rd_ch; 0 if rd_ch >= NUM_CH
- rd_valid  out  1  rd_ch has had at least one successful read
- alarm  out  NUM_CH  per channel, last reading outside [LO, HI]
- err  out  NUM_CH  per channel, last transaction timed out
- round_done  out  1  one-cycle pulse when the last channel of a round completes
- busy  out  1  1 in any state other than IDLE / WAIT_PERIOD
- ctl_addr  out  7  slave address to controller
- ctl_enable  out  1  one-cycle transaction request
- ctl_rw  out  1  constant 1 (read)
- ctl_data_in  in  8  controller data_out
- ctl_ready  in  1  controller idle / transaction complete

## Operation
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, NEXT, WAIT_PERIOD.
- IDLE: if run=1, go to ISSUE with ch=0.
- ISSUE: drive ctl_addr = ADDR_LIST[ch]. When ctl_ready=1, pulse ctl_enable (registered, exactly one cycle), then go to WAIT_BUSY.
- WAIT_BUSY: when ctl_ready=0, go to WAIT_DONE.
- WAIT_DONE: when ctl_ready=1, perform the capture, then go to NEXT:
  - cache[ch] <= ctl_data_in
  - valid[ch] <= 1
  - err[ch] <= 0
  - alarm[ch] <= (data < LO[ch]) || (data > HI[ch]), unsigned compare
- Timeout:
  - A counter is cleared on entry to ISSUE and increments each cycle in ISSUE/WAIT_BUSY/WAIT_DONE.
  - When it reaches TIMEOUT-1: err[ch] <= 1; cache, valid and alarm are unchanged; go to NEXT.
  - If completion and timeout occur in the same cycle, completion wins.
- NEXT:
  - If ch < NUM_CH-1: ch <= ch+1, go to ISSUE.
  - Else: pulse round_done and set ch=0. If run=1, go to WAIT_PERIOD with the period counter loaded with POLL_PERIOD-1; otherwise go to IDLE.
- WAIT_PERIOD:
  - Decrements the counter.
  - At 0, or when poll_now=1, go to ISSUE.
  - If run=0, go to IDLE; this takes priority over poll_now.
- run=0 mid-round: the current transaction and round finish; run is sampled only in NEXT (last channel) and WAIT_PERIOD.
- ctl_addr holds its value outside ISSUE..WAIT_DONE.
- rd_data and rd_valid are combinational from the cache, indexed by rd_ch.
- Asynchronous rst returns to IDLE and clears all cache, valid, alarm, err and counters. In-flight controller activity is abandoned.

## Timing
- Reset values: rd_data=0, rd_valid=0, alarm=0, err=0, round_done=0, busy=0, ctl_enable=0, ctl_addr=0, ctl_rw=1.
- ctl_enable asserts in the cycle after ISSUE sees ctl_ready=1. The earliest ctl_enable is 2 cycles after run rises from IDLE.
- Cache, alarm and err update on the clock edge where WAIT_DONE sees ctl_ready=1. They are visible on rd_data / alarm the next cycle.
- Minimum transaction cost is 4 cycles plus the controller's busy time. Round period = sum of transactions + POLL_PERIOD + NUM_CH NEXT cycles.
- poll_now outside WAIT_PERIOD is ignored, not queued.

## Test plan
- NUM_CH=2 with a bus-functional controller returning 8'd50 for 7'h2B and 8'd25 for 7'h2A → after the first round_done: rd_ch=0 gives 25, rd_ch=1 gives 50, alarm=2'b00, err=2'b00.
- Channel 1 returns 8'd120 → alarm[1]=1. The next round returns 8'd60 → alarm[1] clears. Boundary values 40 and 100 on channel 1 → no alarm.
- Controller never re-raises ctl_ready for 7'h2B with TIMEOUT=16 → err[1]=1 exactly 16 cycles after ISSUE entry, cached value unchanged, round_done still pulses.
- POLL_PERIOD=1000 with poll_now pulsed 10 cycles into WAIT_PERIOD → ctl_enable for ch0 within 2 cycles; with no pulse, the gap from round_done to the next ctl_enable is 1000 plus 1–2 cycles.
- run deasserted during ch0's transaction → ch1 is still polled, round_done pulses, FSM returns to IDLE, busy=0, no further ctl_enable.
- rst asserted in WAIT_DONE → all outputs at reset values asynchronously; rd_ch=5 returns rd_data=0, rd_valid=0.

Source files
------------

// File: rtl/sensor_poll_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sensor_poll_scheduler
// Purpose  : Round-robin I2C sensor poller. Reads NUM_CH slave devices through
//            a single i2c_controller master at a fixed poll period. It caches
//            the latest byte per channel and flags out-of-limit readings and
//            timed-out transactions.
// Ports    : clk, rst           - clock, asynchronous active-high reset
//            run, poll_now      - polling enable (level), immediate round (pulse)
//            rd_ch/rd_data/rd_valid - indexed combinational cache read port
//            alarm, err         - per-channel limit / timeout flags
//            round_done, busy   - round completion pulse, activity status
//            ctl_*              - handshake with the i2c_controller master
// Revision : 1.0 - initial release
// ============================================================================
module sensor_poll_scheduler #(
    parameter int                  NUM_CH      = 2,
    parameter logic [7*NUM_CH-1:0] ADDR_LIST   = {7'h2B, 7'h2A},
    parameter logic [8*NUM_CH-1:0] LO_LIMIT    = {8'd40, 8'd0},
    parameter logic [8*NUM_CH-1:0] HI_LIMIT    = {8'd100, 8'd40},
    parameter int                  POLL_PERIOD = 1000,
    parameter int                  TIMEOUT     = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              poll_now,
    input  logic [3:0]        rd_ch,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    output logic [NUM_CH-1:0] alarm,
    output logic [NUM_CH-1:0] err,
    output logic              round_done,
    output logic              busy,
    output logic [6:0]        ctl_addr,
    output logic              ctl_enable,
    output logic              ctl_rw,
    input  logic [7:0]        ctl_data_in,
    input  logic              ctl_ready
);

    localparam int             PW          = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int             TW          = $clog2(TIMEOUT);
    localparam logic [PW-1:0]  PERIOD_LOAD = PW'(POLL_PERIOD - 1);
    localparam logic [TW-1:0]  TO_LAST     = TW'(TIMEOUT - 1);
    localparam logic [3:0]     LAST_CH     = 4'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_ISSUE       = 3'd1,
        S_WAIT_BUSY   = 3'd2,
        S_WAIT_DONE   = 3'd3,
        S_NEXT        = 3'd4,
        S_WAIT_PERIOD = 3'd5
    } state_t;

    state_t                  state, state_nx;
    logic [3:0]              ch, ch_nx;
    logic [TW-1:0]           to_cnt;
    logic [PW-1:0]           per_cnt;
    logic [NUM_CH-1:0][7:0]  cache;
    logic [NUM_CH-1:0]       valid;
    logic                    issue_go;
    logic                    in_txn;
    logic                    done_evt;
    logic                    to_evt;
    logic [6:0]              next_addr;
    logic [7:0]              lo_sel;
    logic [7:0]              hi_sel;
    logic                    out_of_range;

    assign ctl_rw   = 1'b1;
    assign busy     = (state != S_IDLE) && (state != S_WAIT_PERIOD);
    assign in_txn   = (state == S_ISSUE) || (state == S_WAIT_BUSY) || (state == S_WAIT_DONE);
    assign done_evt = (state == S_WAIT_DONE) && ctl_ready;
    // Completion in the same cycle as the timeout wins.
    assign to_evt   = in_txn && (to_cnt == TO_LAST) && !done_evt;

    // Per-channel parameter selection: address for the channel about to be
    // issued, limits for the channel currently in flight.
    always_comb begin
        next_addr = 7'd0;
        lo_sel    = 8'd0;
        hi_sel    = 8'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_nx == 4'(i)) next_addr = ADDR_LIST[7*i +: 7];
            if (ch == 4'(i)) begin
                lo_sel = LO_LIMIT[8*i +: 8];
                hi_sel = HI_LIMIT[8*i +: 8];
            end
        end
    end

    assign out_of_range = (ctl_data_in < lo_sel) || (ctl_data_in > hi_sel);

    // Cache read port; out-of-range indices read as zero / not valid.
    always_comb begin
        rd_data  = 8'd0;
        rd_valid = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == 4'(i)) begin
                rd_data  = cache[i];
                rd_valid = valid[i];
            end
        end
    end

    // Next-state and combinational outputs.
    always_comb begin
        state_nx   = state;
        ch_nx      = ch;
        round_done = 1'b0;
        issue_go   = 1'b0;
        case (state)
            S_IDLE: begin
                if (run) begin
                    state_nx = S_ISSUE;
                    ch_nx    = 4'd0;
                end
            end
            S_ISSUE: begin
                if (to_evt) begin
                    state_nx = S_NEXT;
                end else if (ctl_ready) begin
                    issue_go = 1'b1;
                    state_nx = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (to_evt)          state_nx = S_NEXT;
                else if (!ctl_ready) state_nx = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (done_evt || to_evt) state_nx = S_NEXT;
            end
            S_NEXT: begin
                if (ch < LAST_CH) begin
                    ch_nx    = ch + 4'd1;
                    state_nx = S_ISSUE;
                end else begin
                    round_done = 1'b1;
                    ch_nx      = 4'd0;
                    state_nx   = run ? S_WAIT_PERIOD : S_IDLE;
                end
            end
            S_WAIT_PERIOD: begin
                // Dropping run beats an immediate-poll request.
                if (!run)                              state_nx = S_IDLE;
                else if ((per_cnt == '0) || poll_now)  state_nx = S_ISSUE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            ch    <= 4'd0;
        end else begin
            state <= state_nx;
            ch    <= ch_nx;
        end
    end

    // Transaction timeout counter, period counter, controller request.
    // ctl_addr is loaded only on entry to ISSUE so it holds between rounds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt     <= '0;
            per_cnt    <= '0;
            ctl_enable <= 1'b0;
            ctl_addr   <= 7'd0;
        end else begin
            ctl_enable <= issue_go;
            if ((state_nx == S_ISSUE) && (state != S_ISSUE)) begin
                to_cnt   <= '0;
                ctl_addr <= next_addr;
            end else if (in_txn) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if ((state == S_NEXT) && (state_nx == S_WAIT_PERIOD)) begin
                per_cnt <= PERIOD_LOAD;
            end else if ((state == S_WAIT_PERIOD) && (per_cnt != '0)) begin
                per_cnt <= per_cnt - 1'b1;
            end
        end
    end

    // Capture on completion; a timeout only raises err for the channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache <= '0;
            valid <= '0;
            alarm <= '0;
            err   <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch == 4'(i)) begin
                    if (done_evt) begin
                        cache[i] <= ctl_data_in;
                        valid[i] <= 1'b1;
                        err[i]   <= 1'b0;
                        alarm[i] <= out_of_range;
                    end else if (to_evt) begin
                        err[i] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire
